// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALR_LINK,
    S_LUI,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_FUNCT,
    ALUOP_BRANCH,
    ALUOP_JALR
  } aluop_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_JALR = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_BNE  = 4'b1010;
  localparam logic [3:0] ALU_BLT  = 4'b1011;
  localparam logic [3:0] ALU_SLTU = 4'b1100;
  localparam logic [3:0] ALU_BGE  = 4'b1101;
  localparam logic [3:0] ALU_BLTU = 4'b1110;
  localparam logic [3:0] ALU_BGEU = 4'b1111;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef struct packed {
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    aluop_t     alu_op;
  } ctrl_t;

  // Moore control word for a state; branch marks the zero-qualified PC write.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    c.alu_op = ALUOP_ADD;
    case (s)
      S_FETCH: begin
        c.src_b = SRCB_FOUR; c.result_src = RES_ALU;
        c.ir_write = 1'b1;   c.pc_write = 1'b1;
      end
      S_DECODE:    begin c.src_a = SRCA_OLDPC; c.src_b = SRCB_IMM; end
      S_MEMADR:    begin c.src_a = SRCA_RS1;   c.src_b = SRCB_IMM; end
      S_MEMREAD:   begin c.adr_src = 1'b1; c.result_src = RES_ALUOUT; end
      S_MEMWB:     begin c.result_src = RES_RDATA; c.reg_write = 1'b1; end
      S_MEMWRITE:  begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      S_EXECUTER:  begin c.src_a = SRCA_RS1; c.src_b = SRCB_RS2; c.alu_op = ALUOP_FUNCT; end
      S_EXECUTEI:  begin c.src_a = SRCA_RS1; c.src_b = SRCB_IMM; c.alu_op = ALUOP_FUNCT; end
      S_ALUWB:     begin c.result_src = RES_ALUOUT; c.reg_write = 1'b1; end
      S_BRANCH: begin
        c.src_a = SRCA_RS1; c.src_b = SRCB_RS2;
        c.alu_op = ALUOP_BRANCH; c.branch = 1'b1;
      end
      S_JAL: begin
        c.src_a = SRCA_OLDPC; c.src_b = SRCB_FOUR; c.pc_write = 1'b1;
      end
      S_JALR: begin
        c.src_a = SRCA_RS1; c.src_b = SRCB_IMM; c.alu_op = ALUOP_JALR;
        c.result_src = RES_ALU; c.pc_write = 1'b1;
      end
      S_JALR_LINK: begin
        c.src_a = SRCA_OLDPC; c.src_b = SRCB_FOUR;
        c.result_src = RES_ALU; c.reg_write = 1'b1;
      end
      S_LUI:       begin c.result_src = RES_IMM; c.reg_write = 1'b1; end
      default:     c = c;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] imm_decode(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_JAL:           return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:          return IMM_I;
    endcase
  endfunction

  // BEQ/BNE/BLT/BGE/BLTU/BGEU only; 010 and 011 have no branch meaning.
  function automatic logic branch_f3_legal(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: alu-op class + funct fields -> 4-bit ALU code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  aluop_t      i_alu_op,
  input  logic [2:0]  i_funct3,
  input  logic        i_funct7b5,
  input  logic        i_op5,
  output logic [3:0]  o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_JALR: o_alu_control = ALU_JALR;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // op[5] separates R-type from I-type; ADDI with bit 30 set is still ADD
          3'b000:  o_alu_control = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  o_alu_control = ALU_SLL;
          3'b010:  o_alu_control = ALU_SLT;
          3'b011:  o_alu_control = ALU_SLTU;
          3'b100:  o_alu_control = ALU_XOR;
          3'b101:  o_alu_control = i_funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  o_alu_control = ALU_OR;
          default: o_alu_control = ALU_AND;
        endcase
      end
      ALUOP_BRANCH: begin
        // Each code yields zero=1 exactly when the branch is taken.
        case (i_funct3)
          3'b000:  o_alu_control = ALU_SUB;
          3'b001:  o_alu_control = ALU_BNE;
          3'b100:  o_alu_control = ALU_BLT;
          3'b101:  o_alu_control = ALU_BGE;
          3'b110:  o_alu_control = ALU_BLTU;
          3'b111:  o_alu_control = ALU_BGEU;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore main FSM with registered controls plus ALU decoder.
// Optional CTRL_ILLEGAL_TRAP_EN: unknown opcodes / illegal branch funct3 park the FSM in HALT.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [3:0] alu_control,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       illegal_insn
);

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  state_t r_state;
  state_t w_next;
  ctrl_t  r_ctrl;
  logic   w_br_ok;

  assign w_br_ok = branch_f3_legal(funct3);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECUTER;
          OP_ITYPE:          w_next = S_EXECUTEI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          OP_LUI:            w_next = S_LUI;
          OP_AUIPC:          w_next = S_ALUWB;
          default:           w_next = TRAP_EN ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:    w_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:   w_next = S_MEMWB;
      S_MEMWB:     w_next = S_FETCH;
      S_MEMWRITE:  w_next = S_FETCH;
      S_EXECUTER:  w_next = S_ALUWB;
      S_EXECUTEI:  w_next = S_ALUWB;
      S_ALUWB:     w_next = S_FETCH;
      S_BRANCH:    w_next = (TRAP_EN && !w_br_ok) ? S_HALT : S_FETCH;
      S_JAL:       w_next = S_ALUWB;
      S_JALR:      w_next = S_JALR_LINK;
      S_JALR_LINK: w_next = S_FETCH;
      S_LUI:       w_next = S_FETCH;
      S_HALT:      w_next = S_HALT;
      default:     w_next = S_FETCH;
    endcase
  end

  // Control word is precomputed from the next state so outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RESET_STATE;
      r_ctrl  <= state_ctrl(RESET_STATE);
    end else begin
      r_state <= w_next;
      r_ctrl  <= state_ctrl(w_next);
    end
  end

  alu_decoder u_alu_dec (
    .i_alu_op      (r_ctrl.alu_op),
    .i_funct3      (funct3),
    .i_funct7b5    (funct7b5),
    .i_op5         (op[5]),
    .o_alu_control (alu_control)
  );

  assign alu_src_a  = r_ctrl.src_a;
  assign alu_src_b  = r_ctrl.src_b;
  assign result_src = r_ctrl.result_src;
  assign adr_src    = r_ctrl.adr_src;
  assign imm_src    = imm_decode(op);

  // Enables are gated by rst_n so nothing is written while reset is held.
  assign ir_write  = rst_n & r_ctrl.ir_write;
  assign reg_write = rst_n & r_ctrl.reg_write;
  assign mem_write = rst_n & r_ctrl.mem_write;
  assign pc_write  = rst_n & (r_ctrl.pc_write | (r_ctrl.branch & zero & w_br_ok));

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal_insn = (r_state == S_HALT);
`else
  assign illegal_insn = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: instruction table + scoreboard of per-cycle control words.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [3:0] alu_control;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src;
  logic       adr_src, ir_write, pc_write, reg_write, mem_write, illegal_insn;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .alu_control(alu_control), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .mem_write(mem_write), .illegal_insn(illegal_insn)
  );

  // Bench-side state tags
  localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5, ER = 6, EI = 7;
  localparam int AWB = 8, BR = 9, JL = 10, JR = 11, JRL = 12, LU = 13, H = 14;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         n;
    int         st[5];
    logic [3:0] xalu;
    logic       xpcw;
    logic [2:0] xim;
  } vec_t;

  typedef struct {
    string       name;
    logic [18:0] v;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  wire [18:0] got = {illegal_insn, alu_control, alu_src_a, alu_src_b, result_src,
                     imm_src, adr_src, ir_write, pc_write, reg_write, mem_write};

  // {illegal, alu, src_a, src_b, result_src, imm_src, adr, ir_w, pc_w, reg_w, mem_w}
  function automatic logic [18:0] exp_vec(int s, logic [3:0] xalu, logic xpcw, logic [2:0] xim);
    logic [3:0] al; logic [1:0] a, b, rs; logic adr, ir, pc, rw, mw, ill;
    al = 4'b0000; a = 2'b00; b = 2'b00; rs = 2'b00;
    adr = 0; ir = 0; pc = 0; rw = 0; mw = 0; ill = 0;
    case (s)
      F:   begin b = 2'b10; rs = 2'b10; ir = 1; pc = 1; end
      D:   begin a = 2'b01; b = 2'b01; end
      MA:  begin a = 2'b10; b = 2'b01; end
      MR:  begin adr = 1; end
      MWB: begin rs = 2'b01; rw = 1; end
      MW:  begin adr = 1; mw = 1; end
      ER:  begin al = xalu; a = 2'b10; end
      EI:  begin al = xalu; a = 2'b10; b = 2'b01; end
      AWB: begin rw = 1; end
      BR:  begin al = xalu; a = 2'b10; pc = xpcw; end
      JL:  begin a = 2'b01; b = 2'b10; pc = 1; end
      JR:  begin al = 4'b0100; a = 2'b10; b = 2'b01; rs = 2'b10; pc = 1; end
      JRL: begin a = 2'b01; b = 2'b10; rs = 2'b10; rw = 1; end
      LU:  begin rs = 2'b11; rw = 1; end
      H:   begin ill = 1; end
      default: ;
    endcase
    return {ill, al, a, b, rs, xim, adr, ir, pc, rw, mw};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic add(string name, logic [6:0] o, logic [2:0] f3, logic f7, logic z, int n,
                     int s0, int s1, int s2, int s3, int s4,
                     logic [3:0] xalu, logic xpcw, logic [2:0] xim);
    vec_t v;
    v.name = name; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.n = n;
    v.st[0] = s0; v.st[1] = s1; v.st[2] = s2; v.st[3] = s3; v.st[4] = s4;
    v.xalu = xalu; v.xpcw = xpcw; v.xim = xim;
    tbl.push_back(v);
  endtask

  // Drives one instruction; checks the first ncyc cycles, returning at a negedge.
  task automatic run_seq(vec_t v, int ncyc);
    exp_t e;
    op = v.op; funct3 = v.f3; funct7b5 = v.f7; zero = v.z;
    for (int k = 0; k < ncyc; k++) begin
      e.name = $sformatf("%s.c%0d", v.name, k + 1);
      e.v = exp_vec(v.st[k], v.xalu, v.xpcw, v.xim);
      sb.push_back(e);
    end
    for (int k = 0; k < ncyc; k++) begin
      #1;
      e = sb.pop_front();
      check(e.name, {13'd0, got}, {13'd0, e.v});
      @(negedge clk);
    end
  endtask

  task automatic enables_off(string name);
    #1;
    check(name, {28'd0, ir_write, pc_write, reg_write, mem_write}, 32'd0);
  endtask

  initial begin
    vec_t v;
    rst_n = 0; op = 7'b0110011; funct3 = 0; funct7b5 = 0; zero = 0;

    add("lw",    7'b0000011, 3'b010, 0, 0, 5, F, D, MA, MR, MWB, 4'b0000, 0, 3'b000);
    add("sw",    7'b0100011, 3'b010, 0, 0, 4, F, D, MA, MW, 0,   4'b0000, 0, 3'b001);
    add("sub",   7'b0110011, 3'b000, 1, 0, 4, F, D, ER, AWB, 0,  4'b0001, 0, 3'b000);
    add("add",   7'b0110011, 3'b000, 0, 0, 4, F, D, ER, AWB, 0,  4'b0000, 0, 3'b000);
    add("addi7", 7'b0010011, 3'b000, 1, 0, 4, F, D, EI, AWB, 0,  4'b0000, 0, 3'b000);
    add("srai",  7'b0010011, 3'b101, 1, 0, 4, F, D, EI, AWB, 0,  4'b1001, 0, 3'b000);
    add("srl",   7'b0110011, 3'b101, 0, 0, 4, F, D, ER, AWB, 0,  4'b1000, 0, 3'b000);
    add("sll",   7'b0110011, 3'b001, 0, 0, 4, F, D, ER, AWB, 0,  4'b0111, 0, 3'b000);
    add("slti",  7'b0010011, 3'b010, 0, 0, 4, F, D, EI, AWB, 0,  4'b0101, 0, 3'b000);
    add("sltu",  7'b0110011, 3'b011, 0, 0, 4, F, D, ER, AWB, 0,  4'b1100, 0, 3'b000);
    add("xori",  7'b0010011, 3'b100, 0, 0, 4, F, D, EI, AWB, 0,  4'b0110, 0, 3'b000);
    add("or",    7'b0110011, 3'b110, 0, 0, 4, F, D, ER, AWB, 0,  4'b0011, 0, 3'b000);
    add("andi",  7'b0010011, 3'b111, 1, 0, 4, F, D, EI, AWB, 0,  4'b0010, 0, 3'b000);
    add("beq",   7'b1100011, 3'b000, 0, 1, 3, F, D, BR, 0, 0,    4'b0001, 1, 3'b010);
    add("bne",   7'b1100011, 3'b001, 0, 1, 3, F, D, BR, 0, 0,    4'b1010, 1, 3'b010);
    add("bgeu",  7'b1100011, 3'b111, 0, 0, 3, F, D, BR, 0, 0,    4'b1111, 0, 3'b010);
    add("blt",   7'b1100011, 3'b100, 0, 0, 3, F, D, BR, 0, 0,    4'b1011, 0, 3'b010);
    add("bge",   7'b1100011, 3'b101, 0, 1, 3, F, D, BR, 0, 0,    4'b1101, 1, 3'b010);
    add("bltu",  7'b1100011, 3'b110, 0, 1, 3, F, D, BR, 0, 0,    4'b1110, 1, 3'b010);
    add("jal",   7'b1101111, 3'b000, 0, 0, 4, F, D, JL, AWB, 0,  4'b0000, 0, 3'b011);
    add("jalr",  7'b1100111, 3'b000, 0, 0, 4, F, D, JR, JRL, 0,  4'b0000, 0, 3'b000);
    add("lui",   7'b0110111, 3'b000, 0, 0, 3, F, D, LU, 0, 0,    4'b0000, 0, 3'b100);
    add("auipc", 7'b0010111, 3'b000, 0, 0, 3, F, D, AWB, 0, 0,   4'b0000, 0, 3'b100);

    // Reset held two cycles: no enable may assert.
    @(negedge clk); enables_off("rst_hold1");
    @(negedge clk); enables_off("rst_hold2");
    rst_n = 1;

    for (int i = 0; i < tbl.size(); i++) run_seq(tbl[i], tbl[i].n);

    // Reset arriving in MEMREAD aborts the load.
    run_seq(tbl[0], 4);
    rst_n = 0;
    enables_off("midrst_mr");
    @(negedge clk); enables_off("midrst_1");
    @(negedge clk); enables_off("midrst_2");
    rst_n = 1;
    run_seq(tbl[2], 4);

    // Unknown opcode
    v = tbl[3]; v.name = "badop"; v.op = 7'b1111111; v.xim = 3'b000;
    run_seq(v, 2);
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("halt.c%0d", k), {13'd0, got}, {13'd0, exp_vec(H, 0, 0, 3'b000)});
      @(negedge clk);
    end
    rst_n = 0; @(negedge clk); rst_n = 1;
`endif
    run_seq(tbl[1], 4);

    // Illegal branch funct3 with zero=1: ADD, no PC write.
    v = tbl[13]; v.name = "badbr"; v.f3 = 3'b010; v.xalu = 4'b0000; v.xpcw = 0;
    run_seq(v, 3);
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("brhalt.c%0d", k), {13'd0, got}, {13'd0, exp_vec(H, 0, 0, 3'b010)});
      @(negedge clk);
    end
    rst_n = 0; @(negedge clk); rst_n = 1;
`endif
    run_seq(tbl[0], 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
